// File: rtl/plane_motion.sv
// ============================================================================
//  Module   : plane_motion
//  Purpose  : Frame-rate position controller for the player plane. Samples
//             the direction buttons once per frame, produces the clamped
//             top-left origin poX/poY, and runs the fly/crash/respawn
//             sequence with a blinking visible gate while crashed.
//  Options  : PLANE_WRAP_EN - when defined, X wraps around the screen edges
//             instead of clamping (Y always clamps).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module plane_motion #(
  parameter int SCR_W        = 640,
  parameter int SCR_H        = 480,
  parameter int PLANE_W      = 40,
  parameter int PLANE_H      = 40,
  parameter int STEP         = 2,
  parameter int START_X      = 20,
  parameter int START_Y      = 220,
  parameter int CRASH_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        hit,
  output logic [10:0] poX,
  output logic [10:0] poY,
  output logic        visible,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLY   = 2'd1,
    CRASH = 2'd2
  } state_t;

  // Coordinate limits, kept one bit wider than the outputs so that a
  // subtraction below zero shows up as bit 11 set.
  localparam logic [11:0] X_MAX    = 12'(SCR_W - PLANE_W);
  localparam logic [11:0] Y_MAX    = 12'(SCR_H - PLANE_H);
  localparam logic [10:0] X_MAX_11 = 11'(SCR_W - PLANE_W);
  localparam logic [10:0] Y_MAX_11 = 11'(SCR_H - PLANE_H);
  localparam logic [11:0] STEP_12  = 12'(STEP);
  localparam logic [10:0] START_X_11 = 11'(START_X);
  localparam logic [10:0] START_Y_11 = 11'(START_Y);
  localparam logic [8:0]  CRASH_LAST = 9'(CRASH_FRAMES - 1);

  state_t      st;
  logic        hit_latch;
  logic [7:0]  crash_cnt;

  logic [11:0] x_sum;
  logic [11:0] y_sum;
  logic [10:0] x_new;
  logic [10:0] y_new;
  logic [7:0]  cnt_inc;
  logic        crash_done;

  assign state = st;

  // Raw per-axis step: opposing buttons cancel, so only a single press moves.
  always_comb begin
    x_sum = {1'b0, poX};
    y_sum = {1'b0, poY};
    if (btn_right && !btn_left) begin
      x_sum = {1'b0, poX} + STEP_12;
    end else if (btn_left && !btn_right) begin
      x_sum = {1'b0, poX} - STEP_12;
    end
    if (btn_down && !btn_up) begin
      y_sum = {1'b0, poY} + STEP_12;
    end else if (btn_up && !btn_down) begin
      y_sum = {1'b0, poY} - STEP_12;
    end
  end

  // Bound the stepped coordinates; bit 11 set means the step went below zero.
  always_comb begin
    x_new = x_sum[10:0];
    y_new = y_sum[10:0];
`ifdef PLANE_WRAP_EN
    if (x_sum[11]) begin
      x_new = X_MAX_11;
    end else if (x_sum > X_MAX) begin
      x_new = 11'd0;
    end
`else
    if (x_sum[11]) begin
      x_new = 11'd0;
    end else if (x_sum > X_MAX) begin
      x_new = X_MAX_11;
    end
`endif
    if (y_sum[11]) begin
      y_new = 11'd0;
    end else if (y_sum > Y_MAX) begin
      y_new = Y_MAX_11;
    end
  end

  // Crash timer: the tick that brings the counter to CRASH_FRAMES-1 ends it.
  // Compared with >= so a one-frame crash still terminates on its first tick.
  always_comb begin
    cnt_inc    = crash_cnt + 8'd1;
    crash_done = ({1'b0, cnt_inc} >= CRASH_LAST);
  end

  // Fly/crash/respawn sequencer with registered position and visibility.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      poX       <= START_X_11;
      poY       <= START_Y_11;
      visible   <= 1'b1;
      crash_cnt <= 8'd0;
      hit_latch <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (start) begin
            st <= FLY;
          end
        end

        FLY: begin
          if (frame_tick) begin
            if (hit_latch || hit) begin
              st        <= CRASH;
              hit_latch <= 1'b0;
              crash_cnt <= 8'd0;
              visible   <= 1'b1;
            end else begin
              poX <= x_new;
              poY <= y_new;
            end
          end else if (hit) begin
            hit_latch <= 1'b1;
          end
        end

        CRASH: begin
          if (frame_tick) begin
            if (crash_done) begin
              st        <= IDLE;
              poX       <= START_X_11;
              poY       <= START_Y_11;
              visible   <= 1'b1;
              crash_cnt <= 8'd0;
            end else begin
              crash_cnt <= cnt_inc;
              visible   <= ~cnt_inc[3];
            end
          end
        end

        default: begin
          st        <= IDLE;
          hit_latch <= 1'b0;
          crash_cnt <= 8'd0;
          visible   <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_plane_motion.sv
// ============================================================================
//  Module   : tb_plane_motion
//  Purpose  : Scoreboard bench for plane_motion. Expected outputs are queued
//             by the stimulus; monitors pop and compare after each frame
//             tick edge and at explicit observation points.
//  Options  : PLANE_WRAP_EN selects wrap-mode expectations at the X edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plane_motion;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        start;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        hit;
  logic [10:0] poX;
  logic [10:0] poY;
  logic        visible;
  logic [1:0]  state;

  typedef struct {
    string      nm;
    logic [10:0] x;
    logic [10:0] y;
    logic        v;
    logic [1:0]  s;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  event chk_ev;

  plane_motion dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .hit        (hit),
    .poX        (poX),
    .poY        (poY),
    .visible    (visible),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare_out();
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_output: got x=%0d y=%0d vis=%0b st=%0d, no expectation queued",
               poX, poY, visible, state);
    end else begin
      e = sb.pop_front();
      if (poX !== e.x || poY !== e.y || visible !== e.v || state !== e.s) begin
        miscompares++;
        $display("FAIL %s: got x=%0d y=%0d vis=%0b st=%0d, want x=%0d y=%0d vis=%0b st=%0d",
                 e.nm, poX, poY, visible, state, e.x, e.y, e.v, e.s);
      end
    end
  endtask

  // Monitor: outputs change only after frame_tick edges.
  initial begin
    forever begin
      @(posedge clk);
      if (frame_tick === 1'b1) begin
        #1;
        compare_out();
      end
    end
  end

  // Monitor: explicit observation points (async reset, start transitions).
  initial begin
    forever begin
      @(chk_ev);
      compare_out();
    end
  end

  task automatic push_exp(input string nm, input int ex, input int ey, input bit ev, input int es);
    exp_t e;
    e.nm = nm;
    e.x  = 11'(ex);
    e.y  = 11'(ey);
    e.v  = ev;
    e.s  = 2'(es);
    sb.push_back(e);
  endtask

  // One frame tick (optionally with hit in the same cycle) and its expectation.
  task automatic step(input string nm, input int ex, input int ey, input bit ev, input int es,
                      input bit hp = 1'b0);
    push_exp(nm, ex, ey, ev, es);
    @(negedge clk);
    frame_tick = 1'b1;
    hit        = hp;
    @(negedge clk);
    frame_tick = 1'b0;
    hit        = 1'b0;
  endtask

  task automatic check_now(input string nm, input int ex, input int ey, input bit ev, input int es);
    push_exp(nm, ex, ey, ev, es);
    -> chk_ev;
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    int x;
    int y;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    frame_tick  = 1'b0;
    start       = 1'b0;
    btn_up      = 1'b0;
    btn_down    = 1'b0;
    btn_left    = 1'b0;
    btn_right   = 1'b0;
    hit         = 1'b0;

    #3;
    check_now("reset_state", 20, 220, 1'b1, 0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores buttons
    btn_right = 1'b1;
    step("idle_hold", 20, 220, 1'b1, 0);

    pulse_start();
    check_now("start_to_fly", 20, 220, 1'b1, 1);

    // right+down for 5 ticks
    btn_down = 1'b1;
    for (int i = 1; i <= 5; i++) step("move_right_down", 20 + 2 * i, 220 + 2 * i, 1'b1, 1);

    // left+right cancel
    btn_down = 1'b0;
    btn_left = 1'b1;
    for (int i = 0; i < 3; i++) step("left_right_cancel", 30, 230, 1'b1, 1);
    btn_left = 1'b0;

    pulse_start();
    check_now("start_in_fly", 30, 230, 1'b1, 1);

    // walk to x=100, then async reset mid-cycle
    x = 30;
    for (int i = 0; i < 35; i++) begin
      x += 2;
      step("move_to_100", x, 230, 1'b1, 1);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_now("async_reset", 20, 220, 1'b1, 0);
    @(negedge clk);
    rst = 1'b0;

    pulse_start();
    check_now("restart_fly", 20, 220, 1'b1, 1);

    // Y lower clamp
    btn_right = 1'b0;
    btn_up    = 1'b1;
    y = 220;
    for (int i = 0; i < 109; i++) begin
      y -= 2;
      step("move_up", 20, y, 1'b1, 1);
    end
    for (int i = 0; i < 3; i++) step("clamp_y_zero", 20, 0, 1'b1, 1);
    btn_up = 1'b0;

    // X right edge
    btn_right = 1'b1;
    x = 20;
    for (int i = 0; i < 289; i++) begin
      x += 2;
      step("move_right", x, 0, 1'b1, 1);
    end
    step("reach_x_max", 600, 0, 1'b1, 1);
`ifdef PLANE_WRAP_EN
    step("wrap_right", 0, 0, 1'b1, 1);
    btn_right = 1'b0;
    btn_left  = 1'b1;
    step("wrap_left", 600, 0, 1'b1, 1);
    btn_left  = 1'b0;
    btn_right = 1'b1;
`else
    step("clamp_x_max", 600, 0, 1'b1, 1);
    step("clamp_x_max", 600, 0, 1'b1, 1);
`endif

    // Crash: hit coincident with tick while holding right
    step("crash_enter", 600, 0, 1'b1, 2, 1'b1);
    for (int k = 1; k <= 58; k++) begin
      if (k == 20) begin
        @(negedge clk);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
      end
      step("crash_blink", 600, 0, ~k[3], 2);
    end
    step("crash_exit", 20, 220, 1'b1, 0);
    step("idle_after_crash", 20, 220, 1'b1, 0);

    // Sticky hit latch: hit between ticks still crashes at the next tick
    pulse_start();
    check_now("fly_again", 20, 220, 1'b1, 1);
    btn_right = 1'b0;
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    repeat (3) @(negedge clk);
    step("hit_latched", 20, 220, 1'b1, 2);
    step("crash_tick1", 20, 220, 1'b1, 2);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d expectations left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
